// File: rtl/vadd_compute.sv
// Vector-add compute stage: streams A[i] and B[i] from memory, writes C[i] = A[i] + B[i].
// Ports: clock/reset, launch/finish handshake, busy-cycle event counter, host registers
// (length, a/b/c base addresses), one-beat memory request/write/read channels.
module vadd_compute #(
    parameter int HOST_DATA_BITS = 32,
    parameter int MEM_ADDR_BITS  = 64,
    parameter int MEM_LEN_BITS   = 8,
    parameter int MEM_DATA_BITS  = 64
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      launch,
    output logic                      finish,
    output logic                      event_counter_valid,
    output logic [HOST_DATA_BITS-1:0] event_counter_value,
    input  logic [HOST_DATA_BITS-1:0] length,
    input  logic [HOST_DATA_BITS-1:0] a_addr,
    input  logic [HOST_DATA_BITS-1:0] b_addr,
    input  logic [HOST_DATA_BITS-1:0] c_addr,
    output logic                      mem_req_valid,
    output logic                      mem_req_opcode,
    output logic [MEM_LEN_BITS-1:0]   mem_req_len,
    output logic [MEM_ADDR_BITS-1:0]  mem_req_addr,
    output logic                      mem_wr_valid,
    output logic [MEM_DATA_BITS-1:0]  mem_wr_bits,
    input  logic                      mem_rd_valid,
    input  logic [MEM_DATA_BITS-1:0]  mem_rd_bits,
    output logic                      mem_rd_ready
);

    typedef enum logic [2:0] {
        IDLE, REQ_A, WAIT_A, REQ_B, WAIT_B, REQ_C, WR_C, DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [HOST_DATA_BITS-1:0] len_q, len_d;
    logic [MEM_ADDR_BITS-1:0]  a_base_q, a_base_d;
    logic [MEM_ADDR_BITS-1:0]  b_base_q, b_base_d;
    logic [MEM_ADDR_BITS-1:0]  c_base_q, c_base_d;
    logic [HOST_DATA_BITS-1:0] i_q, i_d;
    logic [HOST_DATA_BITS-1:0] cnt_q, cnt_d;
    logic [MEM_DATA_BITS-1:0]  a_q, a_d;
    logic [MEM_DATA_BITS-1:0]  b_q, b_d;

    // Byte offset of element i; wraps in the memory address width.
    logic [MEM_ADDR_BITS-1:0]  elem_ofs;
    assign elem_ofs = MEM_ADDR_BITS'(i_q) << 3;

    // Next-state and datapath register updates.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        a_base_d = a_base_q;
        b_base_d = b_base_q;
        c_base_d = c_base_q;
        i_d      = i_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;

        // Counter reads 0 in the first busy cycle, so it only advances
        // from a busy cycle; it holds in IDLE so the final count stays readable.
        if (state_q != IDLE) begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (launch) begin
                    len_d    = length;
                    a_base_d = MEM_ADDR_BITS'(a_addr);
                    b_base_d = MEM_ADDR_BITS'(b_addr);
                    c_base_d = MEM_ADDR_BITS'(c_addr);
                    i_d      = '0;
                    cnt_d    = '0;
                    state_d  = (length == '0) ? DONE : REQ_A;
                end
            end
            REQ_A:  state_d = WAIT_A;
            WAIT_A: begin
                if (mem_rd_valid) begin
                    a_d     = mem_rd_bits;
                    state_d = REQ_B;
                end
            end
            REQ_B:  state_d = WAIT_B;
            WAIT_B: begin
                if (mem_rd_valid) begin
                    b_d     = mem_rd_bits;
                    state_d = REQ_C;
                end
            end
            REQ_C:  state_d = WR_C;
            WR_C: begin
                i_d     = i_q + 1'b1;
                state_d = (i_q + 1'b1 == len_q) ? DONE : REQ_A;
            end
            DONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            len_q    <= '0;
            a_base_q <= '0;
            b_base_q <= '0;
            c_base_q <= '0;
            i_q      <= '0;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            a_base_q <= a_base_d;
            b_base_q <= b_base_d;
            c_base_q <= c_base_d;
            i_q      <= i_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
        end
    end

    // Outputs decode registered state only; everything not owned by the
    // current state is driven to 0.
    always_comb begin
        finish              = (state_q == DONE);
        event_counter_valid = (state_q != IDLE);
        event_counter_value = cnt_q;
        mem_req_valid       = 1'b0;
        mem_req_opcode      = 1'b0;
        mem_req_len         = '0;
        mem_req_addr        = '0;
        mem_wr_valid        = 1'b0;
        mem_wr_bits         = '0;
        mem_rd_ready        = 1'b0;
        case (state_q)
            REQ_A: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = a_base_q + elem_ofs;
            end
            REQ_B: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = b_base_q + elem_ofs;
            end
            REQ_C: begin
                mem_req_valid  = 1'b1;
                mem_req_opcode = 1'b1;
                mem_req_addr   = c_base_q + elem_ofs;
            end
            WR_C: begin
                mem_wr_valid = 1'b1;
                mem_wr_bits  = a_q + b_q;   // carry out is dropped
            end
            WAIT_A, WAIT_B: mem_rd_ready = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_vadd_compute.sv
// Directed bench for vadd_compute with a simple latency-programmable memory model.
module tb_vadd_compute;

    logic        clock = 1'b0;
    logic        reset;
    logic        launch;
    logic        finish;
    logic        event_counter_valid;
    logic [31:0] event_counter_value;
    logic [31:0] length, a_addr, b_addr, c_addr;
    logic        mem_req_valid;
    logic        mem_req_opcode;
    logic [7:0]  mem_req_len;
    logic [63:0] mem_req_addr;
    logic        mem_wr_valid;
    logic [63:0] mem_wr_bits;
    logic        mem_rd_valid;
    logic [63:0] mem_rd_bits;
    logic        mem_rd_ready;

    vadd_compute dut (
        .clock               (clock),
        .reset               (reset),
        .launch              (launch),
        .finish              (finish),
        .event_counter_valid (event_counter_valid),
        .event_counter_value (event_counter_value),
        .length              (length),
        .a_addr              (a_addr),
        .b_addr              (b_addr),
        .c_addr              (c_addr),
        .mem_req_valid       (mem_req_valid),
        .mem_req_opcode      (mem_req_opcode),
        .mem_req_len         (mem_req_len),
        .mem_req_addr        (mem_req_addr),
        .mem_wr_valid        (mem_wr_valid),
        .mem_wr_bits         (mem_wr_bits),
        .mem_rd_valid        (mem_rd_valid),
        .mem_rd_bits         (mem_rd_bits),
        .mem_rd_ready        (mem_rd_ready)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Memory model state and transaction logs.
    logic [63:0] mem [logic [63:0]];
    logic [63:0] rd_log[$];
    logic [63:0] wa_log[$];
    logic [63:0] wd_log[$];
    logic [63:0] wr_addr;
    logic [63:0] pend;
    int          lat = 1;
    int          cd = 0;
    int          fin_cnt = 0;
    int          rdy_cnt = 0;
    int          bad_len = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Memory: a read requested in cycle k returns its beat in cycle k+lat.
    initial begin
        mem_rd_valid = 1'b0;
        mem_rd_bits  = '0;
        wr_addr      = '0;
        pend         = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                cd = 0;
                mem_rd_valid = 1'b0;
            end else begin
                mem_rd_valid = 1'b0;
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        mem_rd_valid = 1'b1;
                        mem_rd_bits  = mem.exists(pend) ? mem[pend] : 64'hDEAD;
                    end
                end
                if (mem_req_valid) begin
                    if (mem_req_len != 8'd0) bad_len++;
                    if (!mem_req_opcode) begin
                        rd_log.push_back(mem_req_addr);
                        pend = mem_req_addr;
                        cd   = lat;
                    end else begin
                        wr_addr = mem_req_addr;
                    end
                end
                if (mem_wr_valid) begin
                    wa_log.push_back(wr_addr);
                    wd_log.push_back(mem_wr_bits);
                end
                if (finish) fin_cnt++;
                if (mem_rd_ready) rdy_cnt++;
            end
        end
    end

    // One launch: returns cycles from launch to finish and the final count.
    task automatic run(input logic [31:0] n, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, output int cycles, output logic [31:0] final_cnt);
        rd_log.delete();
        wa_log.delete();
        wd_log.delete();
        fin_cnt = 0;
        rdy_cnt = 0;
        length  = n;
        a_addr  = a;
        b_addr  = b;
        c_addr  = c;
        launch  = 1'b1;
        cycles  = 0;
        final_cnt = '0;
        forever begin
            @(negedge clock);
            cycles++;
            launch = 1'b0;
            if (cycles == 1 && n != 0) check("start_latency", {63'd0, mem_req_valid}, 64'd1);
            if (finish) begin
                final_cnt = event_counter_value;
                check("valid_in_done", {63'd0, event_counter_valid}, 64'd1);
                break;
            end
            if (cycles > 2000) begin
                check("finish_timeout", 64'd0, 64'd1);
                break;
            end
        end
        @(negedge clock);
        check("finish_one_cycle", {63'd0, finish}, 64'd0);
        @(negedge clock);
        check("finish_count", 64'(fin_cnt), 64'd1);
    endtask

    int          cyc;
    logic [31:0] fc;
    int          k;

    initial begin
        reset = 1'b1;
        launch = 1'b0;
        length = '0;
        a_addr = '0;
        b_addr = '0;
        c_addr = '0;
        repeat (3) @(negedge clock);
        // Reset state
        check("rst_finish", {63'd0, finish}, 64'd0);
        check("rst_ev_valid", {63'd0, event_counter_valid}, 64'd0);
        check("rst_ev_value", 64'(event_counter_value), 64'd0);
        check("rst_req", {62'd0, mem_req_valid, mem_req_opcode}, 64'd0);
        check("rst_req_addr", mem_req_addr, 64'd0);
        check("rst_wr", {63'd0, mem_wr_valid}, 64'd0);
        check("rst_wr_bits", mem_wr_bits, 64'd0);
        check("rst_rd_ready", {63'd0, mem_rd_ready}, 64'd0);
        reset = 1'b0;
        @(negedge clock);

        // Zero length: DONE one cycle after launch, no traffic
        run(32'd0, 32'h100, 32'h200, 32'h300, cyc, fc);
        check("zero_latency", 64'(cyc), 64'd1);
        check("zero_count", 64'(fc), 64'd0);
        check("zero_reads", 64'(rd_log.size()), 64'd0);
        check("zero_writes", 64'(wa_log.size()), 64'd0);

        // Single element
        mem[64'h100] = 64'd5;
        mem[64'h200] = 64'd7;
        run(32'd1, 32'h100, 32'h200, 32'h300, cyc, fc);
        check("single_latency", 64'(cyc), 64'd7);
        check("single_count", 64'(fc), 64'd6);
        check("single_rd0", rd_log.size() > 0 ? rd_log[0] : 64'hX, 64'h100);
        check("single_rd1", rd_log.size() > 1 ? rd_log[1] : 64'hX, 64'h200);
        check("single_wa", wa_log.size() > 0 ? wa_log[0] : 64'hX, 64'h300);
        check("single_wd", wd_log.size() > 0 ? wd_log[0] : 64'hX, 64'd12);
        check("single_rdy_cycles", 64'(rdy_cnt), 64'd2);

        // Carry dropped: all-ones + (i+1)
        for (int i = 0; i < 4; i++) begin
            mem[64'h1000 + 64'(8 * i)] = 64'hFFFF_FFFF_FFFF_FFFF;
            mem[64'h2000 + 64'(8 * i)] = 64'(i + 1);
        end
        run(32'd4, 32'h1000, 32'h2000, 32'h300, cyc, fc);
        check("wrap_latency", 64'(cyc), 64'd25);
        check("wrap_count", 64'(fc), 64'd24);
        check("wrap_nwrites", 64'(wd_log.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("wrap_wd%0d", i), wd_log.size() > i ? wd_log[i] : 64'hX, 64'(i));
            check($sformatf("wrap_wa%0d", i), wa_log.size() > i ? wa_log[i] : 64'hX,
                  64'h300 + 64'(8 * i));
        end
        check("wrap_rd7", rd_log.size() > 7 ? rd_log[7] : 64'hX, 64'h2018);

        // Memory stall: 5-cycle read latency
        mem[64'h400] = 64'd10;
        mem[64'h408] = 64'd20;
        mem[64'h500] = 64'd1;
        mem[64'h508] = 64'd2;
        lat = 5;
        run(32'd2, 32'h400, 32'h500, 32'h600, cyc, fc);
        check("stall_count", 64'(fc), 64'd28);
        check("stall_rdy_cycles", 64'(rdy_cnt), 64'd20);
        check("stall_wd0", wd_log.size() > 0 ? wd_log[0] : 64'hX, 64'd11);
        check("stall_wd1", wd_log.size() > 1 ? wd_log[1] : 64'hX, 64'd22);
        check("stall_wa1", wa_log.size() > 1 ? wa_log[1] : 64'hX, 64'h608);

        // Reset during WAIT_B of element 1
        lat = 3;
        fin_cnt = 0;
        length = 32'd3;
        a_addr = 32'h400;
        b_addr = 32'h500;
        c_addr = 32'h700;
        launch = 1'b1;
        k = 0;
        for (int t = 0; t < 500 && k < 4; t++) begin
            @(negedge clock);
            launch = 1'b0;
            if (mem_req_valid && !mem_req_opcode) k++;
        end
        check("midrst_reached_req_b1", 64'(k), 64'd4);
        @(negedge clock);
        check("midrst_waiting", {63'd0, mem_rd_ready}, 64'd1);
        reset = 1'b1;
        @(negedge clock);
        check("midrst_ev_valid", {63'd0, event_counter_valid}, 64'd0);
        check("midrst_ev_value", 64'(event_counter_value), 64'd0);
        check("midrst_outs", {59'd0, finish, mem_req_valid, mem_req_opcode, mem_wr_valid,
                              mem_rd_ready}, 64'd0);
        check("midrst_addr_data", mem_req_addr | mem_wr_bits, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        check("midrst_no_finish", 64'(fin_cnt), 64'd0);
        @(negedge clock);
        lat = 1;
        run(32'd1, 32'h100, 32'h200, 32'h380, cyc, fc);
        check("relaunch_count", 64'(fc), 64'd6);
        check("relaunch_wd", wd_log.size() > 0 ? wd_log[0] : 64'hX, 64'd12);

        // Back-to-back runs with new addresses
        run(32'd1, 32'h408, 32'h508, 32'h900, cyc, fc);
        check("b2b_rd0", rd_log.size() > 0 ? rd_log[0] : 64'hX, 64'h408);
        check("b2b_wa", wa_log.size() > 0 ? wa_log[0] : 64'hX, 64'h900);
        check("b2b_wd", wd_log.size() > 0 ? wd_log[0] : 64'hX, 64'd22);
        check("b2b_count", 64'(fc), 64'd6);
        check("req_len_zero", 64'(bad_len), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
